// File: rtl/game_io_pkg.sv
// Shared constants for the KCPSM6 game I/O peripheral: port map, ctrl bit
// positions, interrupt handshake state encoding and the default timer period.
package game_io_pkg;

  localparam int TICK_DIV_DEF = 10_000_000;

  localparam logic [7:0] PORT_BTNS      = 8'h00;
  localparam logic [7:0] PORT_SW        = 8'h01;
  localparam logic [7:0] PORT_LED       = 8'h02;
  localparam logic [7:0] PORT_DIG3      = 8'h03;
  localparam logic [7:0] PORT_DIG2      = 8'h04;
  localparam logic [7:0] PORT_DIG1      = 8'h05;
  localparam logic [7:0] PORT_DIG0      = 8'h06;
  localparam logic [7:0] PORT_DP        = 8'h07;
  localparam logic [7:0] PORT_GAME_INFO = 8'h09;
  localparam logic [7:0] PORT_IRQ_MASK  = 8'h0A;
  localparam logic [7:0] PORT_IRQ_PEND  = 8'h0B;
  localparam logic [7:0] PORT_CTRL      = 8'h0C;
  localparam logic [7:0] PORT_EXT       = 8'h0E;
  localparam logic [7:0] PORT_RAND      = 8'h0F;

  localparam int CTRL_TMR_EN = 0;
  localparam int CTRL_EDGE   = 1;
  localparam logic [7:0] CTRL_RST = 8'h01;

  typedef enum logic [1:0] {
    IRQ_ARMED,
    IRQ_ACTIVE,
    IRQ_DISARMED
  } irq_state_t;

  // OUTPUTK carries only a 4-bit constant port address.
  function automatic logic [7:0] k_port(input logic [3:0] lo);
    return {4'h0, lo};
  endfunction

endpackage

// File: rtl/game_io_ctrl_if.sv
// KCPSM6 I/O bus as seen between the processor (master) and a peripheral (slave).
interface game_io_ctrl_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/game_io_ctrl_irq_ctrl.sv
// Interrupt controller: ext_irq synchronisers, edge/level detect, pending/mask
// registers and the KCPSM6 interrupt/acknowledge handshake.
module irq_ctrl
  import game_io_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [N_IRQ-2:0] ext_irq,
  input  logic             edge_mode,
  input  logic             mask_we,
  input  logic             pend_we,
  input  logic [N_IRQ-1:0] wdata,
  input  logic             ack,
  output logic             interrupt,
  output logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-2:0] ext_sync
);

  logic [N_IRQ-2:0] sync1, sync2, sync_d;
  logic [N_IRQ-2:0] ext_evt;
  logic [N_IRQ-1:0] set_vec, clr_vec;
  logic             irq_req;
  irq_state_t       state;

  assign ext_sync = sync2;
  assign ext_evt  = edge_mode ? (sync2 & ~sync_d) : sync2;
  assign set_vec  = {ext_evt, tick};
  assign clr_vec  = pend_we ? wdata : '0;
  assign irq_req  = |(pending & mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
    end else begin
      sync1  <= ext_irq;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // Set is OR'd in after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (mask_we) mask <= wdata;
    end
  end

  // ARMED raises the request; ack disarms; any pending write re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IRQ_ARMED;
      interrupt <= 1'b0;
    end else if (ack) begin
      state     <= IRQ_DISARMED;
      interrupt <= 1'b0;
    end else begin
      case (state)
        IRQ_ARMED: begin
          if (irq_req) begin
            state     <= IRQ_ACTIVE;
            interrupt <= 1'b1;
          end
        end
        IRQ_ACTIVE: interrupt <= 1'b1;
        IRQ_DISARMED: begin
          interrupt <= 1'b0;
          if (pend_we) state <= IRQ_ARMED;
        end
        default: begin
          state     <= IRQ_ARMED;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/game_io_ctrl.sv
// KCPSM6 peripheral for the game board: display/game registers, periodic
// timer, registered read mux and an interrupt controller.
module game_io_ctrl
  import game_io_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int N_IRQ    = 4
) (
  input  logic             clk,
  input  logic             rst,
  game_io_ctrl_if.slave    bus,
  input  logic [3:0]       db_btns,
  input  logic [7:0]       db_sw,
  input  logic [1:0]       rand_val,
  input  logic [N_IRQ-2:0] ext_irq,
  output logic [7:0]       led,
  output logic [4:0]       dig3,
  output logic [4:0]       dig2,
  output logic [4:0]       dig1,
  output logic [4:0]       dig0,
  output logic [3:0]       dp,
  output logic [7:0]       game_info
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic             wr_en;
  logic [7:0]       wr_addr;
  logic             mask_we, pend_we;
  logic             ctrl_en, ctrl_edge;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [7:0]       rd_data;
  logic [7:0]       in_port_r;
  logic             irq;
  logic [N_IRQ-1:0] mask, pending;
  logic [N_IRQ-2:0] ext_sync;
  logic             unused_rd;

  assign unused_rd = bus.read_strobe;

  // OUTPUT uses the full address; OUTPUTK aliases the low nibble.
  always_comb begin
    wr_en   = bus.write_strobe | bus.k_write_strobe;
    wr_addr = bus.write_strobe ? bus.port_id : k_port(bus.port_id[3:0]);
  end

  assign mask_we = wr_en && (wr_addr == PORT_IRQ_MASK);
  assign pend_we = wr_en && (wr_addr == PORT_IRQ_PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      dig3      <= '0;
      dig2      <= '0;
      dig1      <= '0;
      dig0      <= '0;
      dp        <= '0;
      game_info <= '0;
      ctrl_en   <= CTRL_RST[CTRL_TMR_EN];
      ctrl_edge <= CTRL_RST[CTRL_EDGE];
    end else if (wr_en) begin
      case (wr_addr)
        PORT_LED:       led       <= bus.out_port;
        PORT_DIG3:      dig3      <= bus.out_port[4:0];
        PORT_DIG2:      dig2      <= bus.out_port[4:0];
        PORT_DIG1:      dig1      <= bus.out_port[4:0];
        PORT_DIG0:      dig0      <= bus.out_port[4:0];
        PORT_DP:        dp        <= bus.out_port[3:0];
        PORT_GAME_INFO: game_info <= bus.out_port;
        PORT_CTRL: begin
          ctrl_en   <= bus.out_port[CTRL_TMR_EN];
          ctrl_edge <= bus.out_port[CTRL_EDGE];
        end
        default: ;
      endcase
    end
  end

  assign tick = ctrl_en && (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !ctrl_en) cnt <= '0;
    else if (tick)       cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.port_id)
      PORT_BTNS:     rd_data = {4'b0, db_btns};
      PORT_SW:       rd_data = db_sw;
      PORT_LED:      rd_data = led;
      PORT_IRQ_MASK: rd_data = 8'(mask);
      PORT_IRQ_PEND: rd_data = 8'(pending);
      PORT_CTRL:     rd_data = {6'b0, ctrl_edge, ctrl_en};
      PORT_EXT:      rd_data = 8'(ext_sync);
      PORT_RAND:     rd_data = {6'b0, rand_val};
      default:       rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) in_port_r <= '0;
    else     in_port_r <= rd_data;
  end

  assign bus.in_port   = in_port_r;
  assign bus.interrupt = irq;

  irq_ctrl #(.N_IRQ(N_IRQ)) u_irq (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .ext_irq   (ext_irq),
    .edge_mode (ctrl_edge),
    .mask_we   (mask_we),
    .pend_we   (pend_we),
    .wdata     (bus.out_port[N_IRQ-1:0]),
    .ack       (bus.interrupt_ack),
    .interrupt (irq),
    .mask      (mask),
    .pending   (pending),
    .ext_sync  (ext_sync)
  );

endmodule

// File: tb/tb_game_io_ctrl.sv
// Directed plus randomized bench for game_io_ctrl with a register/edge model
// kept in the bench; runs with an 8-cycle timer and four interrupt sources.
module tb_game_io_ctrl;
  import game_io_pkg::*;

  localparam int TD = 8;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    db_btns = '0;
  logic [7:0]    db_sw = '0;
  logic [1:0]    rand_val = '0;
  logic [NI-2:0] ext_irq = '0;
  logic [7:0]    led, game_info;
  logic [4:0]    dig3, dig2, dig1, dig0;
  logic [3:0]    dp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]    m_led, m_gi;
  logic [4:0]    m_dig [4];
  logic [3:0]    m_dp;

  logic [7:0]    rdv, a, eff, d;
  bit            k;
  int            rise [3];
  logic [NI-2:0] prev, v, expv;

  game_io_ctrl_if bus();

  game_io_ctrl #(.TICK_DIV(TD), .N_IRQ(NI)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .db_btns(db_btns), .db_sw(db_sw), .rand_val(rand_val), .ext_irq(ext_irq),
    .led(led), .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .dp(dp), .game_info(game_info)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data, input bit kw);
    bus.port_id  = addr;
    bus.out_port = data;
    if (kw) bus.k_write_strobe = 1'b1;
    else    bus.write_strobe   = 1'b1;
    step();
    bus.write_strobe   = 1'b0;
    bus.k_write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    step();
    data = bus.in_port;
    bus.read_strobe = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.interrupt_ack = 1'b1;
    step();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic quiesce(input logic [7:0] ctrl);
    wr(PORT_CTRL, ctrl, 1'b0);
    wr(PORT_IRQ_PEND, 8'hFF, 1'b0);
    ack_pulse();
    wr(PORT_IRQ_PEND, 8'h00, 1'b0);
  endtask

  task automatic model_wr(input logic [7:0] addr, input logic [7:0] data);
    case (addr)
      8'h02: m_led = data;
      8'h03: m_dig[0] = data[4:0];
      8'h04: m_dig[1] = data[4:0];
      8'h05: m_dig[2] = data[4:0];
      8'h06: m_dig[3] = data[4:0];
      8'h07: m_dp = data[3:0];
      8'h09: m_gi = data;
      default: ;
    endcase
  endtask

  task automatic chk_regs(input string tag);
    chk(tag, {led, dig3, dig2, dig1, dig0, dp, game_info},
        {m_led, m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dp, m_gi});
  endtask

  task automatic model_reset();
    m_led = '0; m_gi = '0; m_dp = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
  endtask

  initial begin
    bus.port_id = 8'h05; bus.out_port = '0;
    bus.write_strobe = 0; bus.k_write_strobe = 0; bus.read_strobe = 0; bus.interrupt_ack = 0;
    model_reset();

    // Reset state
    repeat (3) step();
    chk_regs("rst_regs");
    chk("rst_irq", bus.interrupt, 1'b0);
    chk("rst_in_port", bus.in_port, 8'h00);
    rst = 1'b0;
    rd(PORT_CTRL, rdv);     chk("rst_ctrl", rdv, 8'h01);
    rd(PORT_IRQ_MASK, rdv); chk("rst_mask", rdv, 8'h00);
    rd(PORT_IRQ_PEND, rdv); chk("rst_pend", rdv, 8'h00);

    // Timer: enable lands at edge E, first tick latches at E+8, interrupt at E+9
    quiesce(8'h00);
    wr(PORT_IRQ_MASK, 8'h01, 1'b0);
    wr(PORT_CTRL, 8'h01, 1'b0);
    repeat (8) step();
    chk("tmr_irq_before", bus.interrupt, 1'b0);
    step();
    chk("tmr_irq_first", bus.interrupt, 1'b1);
    rise[0] = cyc;
    bus.interrupt_ack = 1'b1;
    step();
    bus.interrupt_ack = 1'b0;
    chk("tmr_ack_drop", bus.interrupt, 1'b0);
    for (int i = 1; i < 3; i++) begin
      wr(PORT_IRQ_PEND, 8'h01, 1'b0);
      for (int j = 0; j < 20 && !bus.interrupt; j++) step();
      chk("tmr_irq_rise", bus.interrupt, 1'b1);
      rise[i] = cyc;
      chk("tmr_period", rise[i] - rise[i-1], TD);
      ack_pulse();
    end

    // W1C on the same edge as a tick: the tick wins
    for (int j = 0; j < 20 && cyc < rise[2] + 6; j++) step();
    wr(PORT_IRQ_PEND, 8'h01, 1'b0);
    rd(PORT_IRQ_PEND, rdv);
    chk("tick_vs_w1c", rdv, 8'h01);

    // Edge mode, source 1
    quiesce(8'h02);
    wr(PORT_IRQ_MASK, 8'h02, 1'b0);
    bus.port_id = PORT_IRQ_PEND;
    ext_irq = 3'b001;
    repeat (3) step();
    chk("edge_pend_early", bus.in_port, 8'h00);
    chk("edge_irq_early", bus.interrupt, 1'b0);
    step();
    chk("edge_pend_3cyc", bus.in_port, 8'h02);
    chk("edge_irq", bus.interrupt, 1'b1);
    ack_pulse();
    chk("edge_ack", bus.interrupt, 1'b0);
    wr(PORT_IRQ_PEND, 8'h02, 1'b0);
    repeat (4) step();
    chk("edge_no_reassert", bus.interrupt, 1'b0);
    rd(PORT_IRQ_PEND, rdv); chk("edge_w1c", rdv, 8'h00);
    rd(PORT_EXT, rdv);      chk("ext_sync_rd", rdv, 8'h01);

    // Level mode with source held: W1C cannot clear it, write re-arms
    wr(PORT_CTRL, 8'h00, 1'b0);
    for (int j = 0; j < 10 && !bus.interrupt; j++) step();
    chk("lvl_irq", bus.interrupt, 1'b1);
    ack_pulse();
    wr(PORT_IRQ_PEND, 8'h02, 1'b0);
    chk("lvl_w1c_edge", bus.interrupt, 1'b0);
    step();
    chk("lvl_reassert", bus.interrupt, 1'b1);
    rd(PORT_IRQ_PEND, rdv); chk("lvl_pend", rdv, 8'h02);

    // Ack while interrupt is low only disarms
    ext_irq = '0;
    repeat (3) step();
    quiesce(8'h00);
    ack_pulse();
    ext_irq = 3'b010;
    wr(PORT_IRQ_MASK, 8'h06, 1'b0);
    repeat (6) step();
    chk("ack_low_disarm", bus.interrupt, 1'b0);
    rd(PORT_IRQ_PEND, rdv); chk("ack_low_pend", rdv, 8'h04);
    wr(PORT_IRQ_PEND, 8'h00, 1'b0);
    step();
    chk("rearm_write", bus.interrupt, 1'b1);

    // Random ext waveforms in edge mode against a transition-count model
    ext_irq = '0;
    repeat (3) step();
    quiesce(8'h02);
    wr(PORT_IRQ_MASK, 8'h00, 1'b0);
    prev = '0;
    for (int r = 0; r < 4; r++) begin
      wr(PORT_IRQ_PEND, 8'hFF, 1'b0);
      expv = '0;
      for (int i = 0; i < 10; i++) begin
        v = (NI-1)'($urandom);
        expv = expv | (v & ~prev);
        prev = v;
        ext_irq = v;
        step();
      end
      repeat (4) step();
      rd(PORT_IRQ_PEND, rdv);
      chk("rand_edges", rdv, {expv, 1'b0});
    end

    // OUTPUTK aliasing and unmapped writes
    wr(8'h13, 8'h15, 1'b1);
    model_wr(8'h03, 8'h15);
    chk("k_dig3", dig3, 5'h15);
    wr(8'h08, 8'hA5, 1'b0);
    chk_regs("unmapped_wr");
    rd(8'h08, rdv); chk("unmapped_rd", rdv, 8'h00);

    // Random display writes via OUTPUT/OUTPUTK against the register model
    for (int i = 0; i < 40; i++) begin
      k = bit'($urandom_range(0, 1));
      do begin
        a = 8'($urandom);
        eff = k ? {4'h0, a[3:0]} : a;
      end while (eff >= 8'h0A && eff <= 8'h0C);
      d = 8'($urandom);
      wr(a, d, k);
      model_wr(eff, d);
      chk_regs("rand_regs");
      if (i % 4 == 0) begin
        rd(PORT_LED, rdv);
        chk("rand_led_rd", rdv, m_led);
      end
    end

    // Input ports
    for (int i = 0; i < 3; i++) begin
      db_btns = 4'($urandom); db_sw = 8'($urandom); rand_val = 2'($urandom);
      rd(PORT_BTNS, rdv); chk("rd_btns", rdv, {4'h0, db_btns});
      rd(PORT_SW, rdv);   chk("rd_sw", rdv, db_sw);
      rd(PORT_RAND, rdv); chk("rd_rand", rdv, {6'h0, rand_val});
    end

    // Reset while interrupt is active with two pending sources
    ext_irq = '0;
    repeat (3) step();
    quiesce(8'h00);
    wr(PORT_IRQ_MASK, 8'h03, 1'b0);
    ext_irq = 3'b001;
    wr(PORT_CTRL, 8'h01, 1'b0);
    repeat (12) step();
    chk("pre_rst_irq", bus.interrupt, 1'b1);
    rd(PORT_IRQ_PEND, rdv); chk("pre_rst_pend", rdv, 8'h03);
    rst = 1'b1;
    ext_irq = '0;
    step();
    rst = 1'b0;
    model_reset();
    chk("rst_mid_irq", bus.interrupt, 1'b0);
    chk_regs("rst_mid_regs");
    rd(PORT_IRQ_PEND, rdv); chk("rst_mid_pend", rdv, 8'h00);
    rd(PORT_CTRL, rdv);     chk("rst_mid_ctrl", rdv, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
